// File: rtl/block_mm_sequencer.sv
// Control sequencer for tiled matrix multiplication: walks output tiles
// (row, col) and inner tiles k, drives A/B RAM tile addresses, launches the
// systolic array, brackets accumulation and hands finished tiles downstream.
module block_mm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int OUT_W     = 256,
  parameter int K_TILES   = 16,
  parameter int ROW_TILES = 128,
  parameter int COL_TILES = 128,
  parameter int RAM_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [31:0]       tile_limit,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              sys_start,
  input  logic              sys_done,
  output logic              acc_clear,
  output logic              acc_last,
  input  logic              acc_done,
  input  logic [OUT_W-1:0]  acc_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [OUT_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int KW = (K_TILES   > 1) ? $clog2(K_TILES)   : 1;
  localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
  localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;
  localparam int LW = (RAM_LAT   > 1) ? $clog2(RAM_LAT)   : 1;
  localparam logic [31:0] TOTAL = 32'(ROW_TILES * COL_TILES);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_SYS, WAIT_ACC, WRITE, FINISH
  } state_t;

  state_t            state, state_nx;
  logic [KW-1:0]     k;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [LW-1:0]     lat_cnt;
  logic [31:0]       tile_cnt;
  logic [31:0]       limit_r;
  logic [31:0]       eff_limit;
  logic [ADDR_W-1:0] a_base_r, b_base_r;
  logic              lat_done, last_k, last_tile, wr_fire;

  // Tile addresses follow the walk counters directly; wrap modulo 2^ADDR_W.
  assign addr_a  = a_base_r + ADDR_W'(row) * ADDR_W'(K_TILES) + ADDR_W'(k);
  assign addr_b  = b_base_r + ADDR_W'(col) * ADDR_W'(K_TILES) + ADDR_W'(k);
  assign wr_addr = ADDR_W'(row) * ADDR_W'(COL_TILES) + ADDR_W'(col);
  assign busy    = (state != IDLE);

  // Zero or oversized limits both mean "the whole matrix".
  assign eff_limit = (limit_r == 32'd0 || limit_r > TOTAL) ? TOTAL : limit_r;
  assign lat_done  = (lat_cnt == LW'(RAM_LAT - 1));
  assign last_k    = (k == KW'(K_TILES - 1));
  assign last_tile = (tile_cnt + 32'd1 == eff_limit) ||
                     (row == RW'(ROW_TILES - 1) && col == CW'(COL_TILES - 1));
  assign wr_fire   = wr_valid && wr_ready;

  // Next-state and one-cycle control pulses.
  always_comb begin
    state_nx  = state;
    sys_start = 1'b0;
    acc_clear = 1'b0;
    acc_last  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = ISSUE;
      ISSUE:    if (lat_done) begin
                  sys_start = 1'b1;
                  acc_clear = (k == '0);
                  acc_last  = last_k;
                  state_nx  = WAIT_SYS;
                end
      WAIT_SYS: if (sys_done) state_nx = last_k ? WAIT_ACC : ISSUE;
      WAIT_ACC: if (acc_done) state_nx = WRITE;
      WRITE:    if (wr_fire)  state_nx = last_tile ? FINISH : ISSUE;
      FINISH:   begin
                  done     = 1'b1;
                  state_nx = IDLE;
                end
      default:  state_nx = IDLE;
    endcase
  end

  // State register plus the walk counters and the output tile register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      row      <= '0;
      col      <= '0;
      lat_cnt  <= '0;
      tile_cnt <= '0;
      limit_r  <= '0;
      a_base_r <= '0;
      b_base_r <= '0;
      wr_valid <= 1'b0;
      wr_data  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_base_r <= a_base;
          b_base_r <= b_base;
          limit_r  <= tile_limit;
          row      <= '0;
          col      <= '0;
          k        <= '0;
          tile_cnt <= '0;
          lat_cnt  <= '0;
        end
        ISSUE: lat_cnt <= lat_done ? '0 : lat_cnt + 1'b1;
        WAIT_SYS: if (sys_done && !last_k) k <= k + 1'b1;
        WAIT_ACC: if (acc_done) begin
          wr_data  <= acc_data;
          wr_valid <= 1'b1;
        end
        WRITE: if (wr_fire) begin
          wr_valid <= 1'b0;
          tile_cnt <= tile_cnt + 32'd1;
          if (!last_tile) begin
            k <= '0;
            if (col == CW'(COL_TILES - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mm_sequencer.sv
// Directed bench for block_mm_sequencer on a 2x3 tile grid with K_TILES=2.
module tb_block_mm_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, sys_done, acc_done, wr_ready;
  logic [15:0] a_base, b_base;
  logic [31:0] tile_limit, acc_data;
  logic [15:0] addr_a, addr_b, wr_addr;
  logic [31:0] wr_data;
  logic        sys_start, acc_clear, acc_last, wr_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wb, db;

  block_mm_sequencer #(
    .ADDR_W(16), .OUT_W(32), .K_TILES(2), .ROW_TILES(2), .COL_TILES(3), .RAM_LAT(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .a_base(a_base), .b_base(b_base),
    .tile_limit(tile_limit), .addr_a(addr_a), .addr_b(addr_b), .sys_start(sys_start),
    .sys_done(sys_done), .acc_clear(acc_clear), .acc_last(acc_last), .acc_done(acc_done),
    .acc_data(acc_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Handshake and done-pulse counters.
  always @(posedge clock) begin
    if (!reset && wr_valid && wr_ready) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addrs"}, {16'h0, addr_a, addr_b, wr_addr}, 64'h0);
    chk({tag, "_data"}, {32'h0, wr_data}, 64'h0);
    chk({tag, "_ctl"}, {58'h0, wr_valid, sys_start, acc_clear, acc_last, busy, done}, 64'h0);
  endtask

  task automatic start_job(input logic [15:0] ab, input logic [15:0] bb, input logic [31:0] lim);
    a_base = ab; b_base = bb; tile_limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_sys_start_n1", sys_start, 1);
  endtask

  // One inner-tile product: check the launch, then answer sys_done 2 cycles later.
  task automatic issue(input logic [15:0] ea, input logic [15:0] eb, input logic clr,
                       input logic lst, input bit spur, input bit rst_mid);
    int i;
    i = 0;
    while (sys_start !== 1'b1 && i < 8) begin tick(); i++; end
    chk("sys_start_seen", sys_start, 1);
    chk("addr_a", addr_a, ea);
    chk("addr_b", addr_b, eb);
    chk("acc_clear", acc_clear, clr);
    chk("acc_last", acc_last, lst);
    tick();
    chk("sys_start_one_cycle", sys_start, 0);
    if (rst_mid) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("mid_reset");
      return;
    end
    if (spur) begin
      acc_done = 1'b1; acc_data = 32'hBAD0BAD0; start = 1'b1; a_base = a_base ^ 16'h0F0F;
      tick();
      acc_done = 1'b0; start = 1'b0; a_base = a_base ^ 16'h0F0F;
      chk("spur_wait_sys_wr_valid", wr_valid, 0);
      chk("spur_wait_sys_sys_start", sys_start, 0);
      chk("spur_wait_sys_addr_a", addr_a, ea);
      chk("spur_wait_sys_busy", busy, 1);
    end else begin
      tick();
    end
    sys_done = 1'b1;
    tick();
    sys_done = 1'b0;
  endtask

  task automatic accum(input logic [31:0] d, input bit spur);
    if (spur) begin
      sys_done = 1'b1;
      tick();
      sys_done = 1'b0;
      chk("spur_wait_acc_wr_valid", wr_valid, 0);
      chk("spur_wait_acc_sys_start", sys_start, 0);
      chk("spur_wait_acc_busy", busy, 1);
    end else begin
      tick();
    end
    acc_done = 1'b1; acc_data = d;
    tick();
    acc_done = 1'b0; acc_data = 32'hDEADBEEF;
  endtask

  task automatic write_tile(input logic [15:0] ewa, input logic [31:0] ed, input int hold,
                            input bit last);
    chk("wr_valid", wr_valid, 1);
    chk("wr_addr", wr_addr, ewa);
    chk("wr_data", wr_data, ed);
    for (int h = 0; h < hold; h++) begin
      wr_ready = 1'b0;
      tick();
      chk("bp_wr_valid", wr_valid, 1);
      chk("bp_wr_addr", wr_addr, ewa);
      chk("bp_wr_data", wr_data, ed);
      chk("bp_no_sys_start", sys_start, 0);
    end
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    chk("wr_valid_cleared", wr_valid, 0);
    if (last) begin
      chk("done_pulse", done, 1);
      chk("busy_in_finish", busy, 1);
      tick();
      chk("done_cleared", done, 0);
      chk("busy_after_done", busy, 0);
    end else begin
      chk("next_tile_sys_start", sys_start, 1);
    end
  endtask

  task automatic run_tile(input int r, input int c, input logic [15:0] ab, input logic [15:0] bb,
                          input logic [31:0] d, input int hold, input bit spur, input bit last);
    issue(ab + 16'(r * 2),     bb + 16'(c * 2),     1'b1, 1'b0, spur, 1'b0);
    issue(ab + 16'(r * 2 + 1), bb + 16'(c * 2 + 1), 1'b0, 1'b1, 1'b0, 1'b0);
    accum(d, spur);
    write_tile(16'(r * 3 + c), d, hold, last);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; acc_done = 1'b1; sys_done = 1'b0; wr_ready = 1'b0;
    a_base = 16'h0; b_base = 16'h0; tile_limit = 32'd0; acc_data = 32'h0;

    // Reset dominates start and acc_done.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("reset");
    end
    reset = 1'b0; start = 1'b0; acc_done = 1'b0;
    tick();
    chk_zero("post_reset_idle");

    // Full job with spurious inputs on tile 0 and backpressure on tile 2.
    wb = wr_cnt; db = done_cnt;
    start_job(16'h0000, 16'h0000, 32'd0);
    run_tile(0, 0, 16'h0000, 16'h0000, 32'hD000, 0, 1'b1, 1'b0);
    run_tile(0, 1, 16'h0000, 16'h0000, 32'hD001, 0, 1'b0, 1'b0);
    run_tile(0, 2, 16'h0000, 16'h0000, 32'hD002, 5, 1'b0, 1'b0);
    run_tile(1, 0, 16'h0000, 16'h0000, 32'hD003, 0, 1'b0, 1'b0);
    run_tile(1, 1, 16'h0000, 16'h0000, 32'hD004, 0, 1'b0, 1'b0);
    run_tile(1, 2, 16'h0000, 16'h0000, 32'hD005, 0, 1'b0, 1'b1);
    chk("full_job_writes", wr_cnt - wb, 6);
    chk("full_job_done_pulses", done_cnt - db, 1);

    // Limited job with nonzero bases; addr_b wraps 0xFFFF -> 0x0000.
    tick();
    wb = wr_cnt; db = done_cnt;
    start_job(16'h0100, 16'hFFFF, 32'd4);
    run_tile(0, 0, 16'h0100, 16'hFFFF, 32'hE000, 0, 1'b0, 1'b0);
    run_tile(0, 1, 16'h0100, 16'hFFFF, 32'hE001, 0, 1'b0, 1'b0);
    run_tile(0, 2, 16'h0100, 16'hFFFF, 32'hE002, 0, 1'b0, 1'b0);
    run_tile(1, 0, 16'h0100, 16'hFFFF, 32'hE003, 0, 1'b0, 1'b1);
    chk("limit_job_writes", wr_cnt - wb, 4);
    chk("limit_job_done_pulses", done_cnt - db, 1);

    // Reset in WAIT_SYS of tile 3, then restart from tile (0,0).
    tick();
    start_job(16'h0000, 16'h0000, 32'd0);
    run_tile(0, 0, 16'h0000, 16'h0000, 32'hF000, 0, 1'b0, 1'b0);
    run_tile(0, 1, 16'h0000, 16'h0000, 32'hF001, 0, 1'b0, 1'b0);
    run_tile(0, 2, 16'h0000, 16'h0000, 32'hF002, 0, 1'b0, 1'b0);
    issue(16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    start_job(16'h0020, 16'h0040, 32'd0);
    issue(16'h0020, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_mm_sequencer.md
# block_mm_sequencer

Synthesizable control sequencer for tiled matrix multiplication. It turns the address and handshake sequencing that the block-multiplication bench did by hand into a reusable block. The sequencer walks every output tile (row, col) and every inner-dimension tile k, and generates tile addresses for the A and B input RAMs. It launches the systolic array, brackets accumulation with clear/last markers, and hands each finished output tile downstream over a valid/ready write port. It sits between the input RAM, the systolic array/accumulator datapath and the output sink.

## Interface
- ADDR_W, 16, width of RAM tile addresses and write address
- OUT_W, 256, width of an accumulated output tile
- K_TILES, 16, inner-dimension tiles per output tile (>=1)
- ROW_TILES, 128, output tile rows (>=1)
- COL_TILES, 128, output tile columns (>=1)
- RAM_LAT, 1, read latency of the input RAM in cycles (>=1)

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begins a job; sampled only in IDLE
- a_base  in  ADDR_W  A base address, captured on accepted start
- b_base  in  ADDR_W  B base address, captured on accepted start
- tile_limit  in  32  output tiles to process; 0 means ROW_TILES*COL_TILES; captured on start
- addr_a  out  ADDR_W  A tile address
- addr_b  out  ADDR_W  B tile address
- sys_start  out  1  one-cycle launch pulse to the systolic array
- sys_done  in  1  array finished current product
- acc_clear  out  1  pulse with sys_start when k==0
- acc_last  out  1  pulse with sys_start when k==K_TILES-1
- acc_done  in  1  accumulator result valid on acc_data
- acc_data  in  OUT_W  accumulated tile
- wr_valid  out  1  output tile available
- wr_ready  in  1  sink accepts tile
- wr_data  out  OUT_W  registered output tile
- wr_addr  out  ADDR_W  row*COL_TILES+col
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, ISSUE, WAIT_SYS, WAIT_ACC, WRITE, FINISH.
- Address arithmetic:
  - addr_a = a_base + row*K_TILES + k.
  - addr_b = b_base + col*K_TILES + k.
  - wr_addr = row*COL_TILES + col.
  - All three are computed modulo 2^ADDR_W (truncated, no error).
- IDLE, start=1:
  - Capture bases and limit.
  - Set row=col=k=0 and tile_cnt=0.
  - Load addresses and go to ISSUE.
- ISSUE:
  - Latency counter counts RAM_LAT cycles with addresses held.
  - On expiry, pulse sys_start (plus acc_clear/acc_last as applicable) and go to WAIT_SYS.
- WAIT_SYS, on sys_done:
  - If k<K_TILES-1: increment k, load new addresses, go to ISSUE.
  - Otherwise go to WAIT_ACC.
- WAIT_ACC, on acc_done: register acc_data into wr_data, set wr_valid=1, go to WRITE.
- WRITE, on wr_valid&&wr_ready:
  - Clear wr_valid and increment tile_cnt.
  - If tile_cnt+1 equals the effective limit, or (row,col) is the last tile, go to FINISH.
  - Otherwise advance col; when col wraps from COL_TILES-1 to 0, increment row. Then set k=0, load addresses, go to ISSUE.
- FINISH: done=1 for one cycle, then IDLE.
- Boundary and ignore rules:
  - sys_done is ignored outside WAIT_SYS; acc_done is ignored outside WAIT_ACC.
  - start while busy is ignored.
  - With K_TILES==1, acc_clear and acc_last pulse in the same cycle.
  - A tile_limit larger than the total is clamped to the total.
- Reset at any time: next cycle state IDLE and all counters 0.

## Timing
- Reset values: every output 0 (addr_a, addr_b, wr_addr, wr_data included); busy=0.
- Accepted start at edge n: addresses valid and busy=1 from cycle n+1; sys_start is high in cycle n+RAM_LAT.
- sys_done seen at edge m with more k remaining: new addresses from m+1, sys_start in m+RAM_LAT.
- acc_done at edge m: wr_valid and wr_data valid from m+1.
- Backpressure: while wr_valid=1 and wr_ready=0, wr_valid, wr_data and wr_addr are held stable and no sys_start is issued.
- Handshake completes at edge w:
  - Next tile's addresses are valid at w+1.
  - Or, for the last tile, done=1 in cycle w+1 and busy=0 from w+2.
- wr_valid never drops without a handshake, except on reset.

## Test plan
- Reset: hold reset 3 cycles with start=1 and acc_done=1 → all outputs 0 and state stays IDLE.
- Full job, K_TILES=2, ROW_TILES=2, COL_TILES=3, RAM_LAT=1, bases 0, responders answer 2 cycles after each request:
  - Tile (0,0) uses (addr_a,addr_b)=(0,0),(1,1); tile (0,1) uses (0,2),(1,3); tile (1,0) uses (2,0),(3,1).
  - Six writes with wr_addr 0..5, one done pulse.
- Backpressure: hold wr_ready=0 for 5 cycles on the tile with wr_addr=2 → wr_valid, wr_data and wr_addr are constant and there is no sys_start. Release → addresses for tile (1,0) appear next cycle.
- Limit and bases: tile_limit=4, a_base=0x100, b_base=0xFFFF → exactly 4 writes.
  - Last wr_addr=3 (row 1, col 0).
  - First addr_b wraps: 0xFFFF, then 0x0000.
- Spurious inputs: sys_done in WAIT_ACC, acc_done in WAIT_SYS, and start while busy → no state change and no extra pulses.
- Reset mid-job: assert reset in WAIT_SYS of tile 3 → IDLE and zero outputs next cycle. A new start restarts from tile (0,0), k=0.
